db_edge_fsm: RTL and testbench

Debounces one raw mechanical switch or button input and produces a clean level plus single-cycle rising and falling edge ticks. It sits directly upstream of the button-driven counter and clear logic on the board top level. It replaces the ad-hoc edge-detect registers there: consumers take `rise_tick`/`fall_tick` directly. It uses a synchronizer, a free-running sample-tick generator and a four-state debounce FSM that requires a stable level across several consecutive sample ticks.

---
 rtl/db_pkg.sv | 21 ++
 rtl/db_edge_fsm_tick_gen.sv | 23 ++
 rtl/db_edge_fsm.sv | 111 +++++++++++
 tb/tb_db_edge_fsm.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/db_pkg.sv
// Shared state encoding and default parameters for the switch debouncer.
// Used by db_edge_fsm and anything that decodes its state.
package db_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    WAIT1 = 2'd1,
    ONE   = 2'd2,
    WAIT0 = 2'd3
  } db_state_t;

  localparam int DEF_TICK_W      = 20;
  localparam int DEF_STABLE_N    = 3;
  localparam int DEF_SYNC_STAGES = 2;

  // Bits needed to hold a count of 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/db_edge_fsm_tick_gen.sv
// Free-running sample-tick generator: m_tick pulses once every 2^TICK_W cycles.
// Latency: first pulse 2^TICK_W-1 cycles after reset release; no backpressure.
module tick_gen #(
  parameter int TICK_W = 20
) (
  input  logic clk,
  input  logic reset_n,
  output logic m_tick
);

  logic [TICK_W-1:0] q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      q <= '0;
    end else begin
      q <= q + TICK_W'(1);
    end
  end

  assign m_tick = &q;

endmodule

// File: rtl/db_edge_fsm.sv
// Switch debouncer: synchronizer, sample ticks and a 4-state qualifier giving db plus edge ticks.
// Latency: SYNC_STAGES+1 cycles to WAIT entry, then (STABLE_N-1)*P+1..STABLE_N*P to db change; no backpressure.
module db_edge_fsm
  import db_pkg::*;
#(
  parameter int TICK_W      = DEF_TICK_W,
  parameter int STABLE_N    = DEF_STABLE_N,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw,
  output logic db,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CNT_W = cnt_width(STABLE_N);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(STABLE_N);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sw_s;
  logic                   m_tick;

  db_state_t        state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rise_nxt, fall_nxt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sw};
    end
  end

  assign sw_s = sync_q[SYNC_STAGES-1];

  tick_gen #(
    .TICK_W (TICK_W)
  ) u_tick_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .m_tick  (m_tick)
  );

  // A reversal in either WAIT state drops straight back, so qualification restarts from zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
    case (state)
      ZERO: begin
        if (sw_s) begin
          state_nxt = WAIT1;
          cnt_nxt   = '0;
        end
      end
      WAIT1: begin
        if (!sw_s) begin
          state_nxt = ZERO;
        end else if (m_tick) begin
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt_nxt == CNT_DONE) begin
            state_nxt = ONE;
            rise_nxt  = 1'b1;
          end
        end
      end
      ONE: begin
        if (!sw_s) begin
          state_nxt = WAIT0;
          cnt_nxt   = '0;
        end
      end
      WAIT0: begin
        if (sw_s) begin
          state_nxt = ONE;
        end else if (m_tick) begin
          cnt_nxt = cnt + CNT_W'(1);
          if (cnt_nxt == CNT_DONE) begin
            state_nxt = ZERO;
            fall_nxt  = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ZERO;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ZERO;
      cnt       <= '0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      rise_tick <= rise_nxt;
      fall_tick <= fall_nxt;
    end
  end

  assign db = (state == ONE) || (state == WAIT0);

endmodule

// File: tb/tb_db_edge_fsm.sv
// Bench for db_edge_fsm with P=4, STABLE_N=3: a cycle model pushes expected outputs
// at each rising edge and they are popped and compared at the following falling edge.
module tb_db_edge_fsm;

  localparam int TICK_W      = 2;
  localparam int STABLE_N    = 3;
  localparam int SYNC_STAGES = 2;
  localparam int P           = 1 << TICK_W;
  localparam int LAT_LO      = SYNC_STAGES + 1 + (STABLE_N - 1) * P + 1;
  localparam int LAT_HI      = SYNC_STAGES + 1 + STABLE_N * P;

  logic clk = 1'b0;
  logic reset_n;
  logic sw;
  logic db;
  logic rise_tick;
  logic fall_tick;

  int n_checks = 0;
  int n_errors = 0;

  db_edge_fsm #(
    .TICK_W      (TICK_W),
    .STABLE_N    (STABLE_N),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sw        (sw),
    .db        (db),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model, written against the behavioural description.
  logic [2:0] exp_q[$];
  int  m_sync0 = 0, m_sync1 = 0, m_q = 0, m_st = 0, m_cnt = 0;

  initial forever begin
    int tick, sws, r, f;
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_sync0 = 0; m_sync1 = 0; m_q = 0; m_st = 0; m_cnt = 0;
      exp_q.delete();
    end else begin
      tick = (m_q == P - 1) ? 1 : 0;
      sws  = m_sync1;
      m_sync1 = m_sync0;
      m_sync0 = (sw === 1'b1) ? 1 : 0;
      m_q = (m_q + 1) % P;
      r = 0; f = 0;
      case (m_st)
        0: if (sws == 1) begin m_st = 1; m_cnt = 0; end
        1: if (sws == 0) m_st = 0;
           else if (tick == 1) begin
             m_cnt++;
             if (m_cnt == STABLE_N) begin m_st = 2; r = 1; end
           end
        2: if (sws == 0) begin m_st = 3; m_cnt = 0; end
        default: if (sws == 1) m_st = 2;
           else if (tick == 1) begin
             m_cnt++;
             if (m_cnt == STABLE_N) begin m_st = 0; f = 1; end
           end
      endcase
      exp_q.push_back({(m_st >= 2) ? 1'b1 : 1'b0, r[0], f[0]});
    end
  end

  int n_rise = 0, n_fall = 0, n_db_hi = 0, n_edge_bad = 0;
  logic prev_db = 1'b0;

  initial forever begin
    logic [2:0] e;
    @(negedge clk);
    if (reset_n === 1'b1 && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("db", int'(db), int'(e[2]));
      chk("rise_tick", int'(rise_tick), int'(e[1]));
      chk("fall_tick", int'(fall_tick), int'(e[0]));
    end
    if (rise_tick === 1'b1) begin
      n_rise++;
      if (!(db === 1'b1 && prev_db === 1'b0)) n_edge_bad++;
    end
    if (fall_tick === 1'b1) begin
      n_fall++;
      if (!(db === 1'b0 && prev_db === 1'b1)) n_edge_bad++;
    end
    if (db === 1'b1) n_db_hi++;
    prev_db = db;
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Counts falling edges until db reaches level v; returns 999 if it never does.
  task automatic wait_db(input logic v, output int lat);
    lat = 999;
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (db === v) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic chk_idle(input string tag);
    #1;
    chk({tag, "_db"}, int'(db), 0);
    chk({tag, "_rise"}, int'(rise_tick), 0);
    chk({tag, "_fall"}, int'(fall_tick), 0);
  endtask

  initial begin
    int lat, r0, f0, h0;
    reset_n = 1'b1;
    sw      = 1'b0;
    #2 reset_n = 1'b0;
    chk_idle("reset");
    cycles(3);
    reset_n = 1'b1;
    cycles(5);

    // Clean press
    r0 = n_rise; f0 = n_fall;
    sw = 1'b1;
    wait_db(1'b1, lat);
    chk("press_latency_ok", (lat >= LAT_LO && lat <= LAT_HI) ? 1 : 0, 1);
    cycles(40 - lat);
    chk("press_rise_count", n_rise - r0, 1);
    chk("press_fall_count", n_fall - f0, 0);

    // Release
    r0 = n_rise; f0 = n_fall;
    sw = 1'b0;
    wait_db(1'b0, lat);
    chk("release_latency_ok", (lat >= LAT_LO && lat <= LAT_HI) ? 1 : 0, 1);
    cycles(40 - lat);
    chk("release_fall_count", n_fall - f0, 1);
    chk("release_rise_count", n_rise - r0, 0);

    // Short glitch
    r0 = n_rise; f0 = n_fall; h0 = n_db_hi;
    sw = 1'b1;
    cycles(6);
    sw = 1'b0;
    cycles(30);
    chk("glitch_db_high", n_db_hi - h0, 0);
    chk("glitch_ticks", (n_rise - r0) + (n_fall - f0), 0);

    // Bounce then hold
    r0 = n_rise; h0 = n_db_hi;
    for (int i = 0; i < 10; i++) begin
      sw = ~sw;
      cycles(3);
    end
    chk("bounce_db_high", n_db_hi - h0, 0);
    chk("bounce_rise_during", n_rise - r0, 0);
    sw = 1'b1;
    cycles(40);
    chk("bounce_rise_count", n_rise - r0, 1);
    chk("bounce_db_final", int'(db), 1);
    sw = 1'b0;
    cycles(40);

    // Reset while qualifying a press
    sw = 1'b1;
    cycles(6);
    #2 reset_n = 1'b0;
    chk_idle("rst_wait1");
    cycles(3);
    r0 = n_rise;
    reset_n = 1'b1;
    wait_db(1'b1, lat);
    chk("rst_wait1_requalify_ok", (lat >= LAT_LO && lat <= LAT_HI) ? 1 : 0, 1);
    chk("rst_wait1_rise_count", n_rise - r0, 1);
    cycles(8);

    // Reset while db is high
    f0 = n_fall;
    chk("rst_one_db_before", int'(db), 1);
    #3 reset_n = 1'b0;
    chk_idle("rst_one");
    sw = 1'b0;
    cycles(3);
    reset_n = 1'b1;
    cycles(30);
    chk("rst_one_fall_count", n_fall - f0, 0);
    chk("rst_one_db_after", int'(db), 0);

    chk("edge_coincidence", n_edge_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
